// File: rtl/riscv_pkg.sv
// Shared rv32 core types, extended with the commit-trace record, capture states and capture modes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } trace_state_e;

  typedef enum logic {
    STOP      = 1'b0,
    OVERWRITE = 1'b1
  } trace_mode_e;

endpackage

// File: rtl/trace_fifo.sv
// Trace record FIFO: storage, wrapping pointers and occupancy count,
// with optional overwrite of the oldest entry when a push hits a full FIFO.
module trace_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             ovw_i,
  input  trace_entry_t     data_i,
  output trace_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_c, empty_c, pop_c, wr_c, ovw_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign pop_c   = pop_i && !empty_c;
  // A full-FIFO push only lands if a pop frees a slot or overwrite is enabled.
  assign wr_c    = push_i && !clear_i && (!full_c || pop_c || ovw_i);
  assign ovw_c   = wr_c && full_c && !pop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c || ovw_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_c && !pop_c && !ovw_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !wr_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement-trace capture: arm/trigger FSM and retired/dropped counters in front of a
// trace FIFO that a consumer drains over valid/ready.
module commit_trace_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_en_i,
  input  logic             cfg_mode_i,
  input  logic             cfg_trig_en_i,
  input  logic [XLEN-1:0]  cfg_trig_pc_i,
  input  logic             commit_valid_i,
  input  logic [XLEN-1:0]  commit_pc_i,
  input  logic [31:0]      commit_instr_i,
  input  logic             commit_rd_we_i,
  input  logic [4:0]       commit_rd_addr_i,
  input  logic [XLEN-1:0]  commit_rd_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output trace_entry_t     out_entry_o,
  output logic [CNT_W-1:0] count_o,
  output logic [63:0]      retired_o,
  output logic [31:0]      dropped_o,
  output logic [1:0]       state_o
);

  trace_state_e     state_q, state_d;
  trace_mode_e      mode_q, mode_d;
  logic [63:0]      retired_q, retired_d;
  logic [31:0]      dropped_q, dropped_d;
  logic [CNT_W-1:0] count_c;
  trace_entry_t     entry_c;
  logic             trig_hit_c, pop_c, full_c;
  logic             clear_c, push_c, retire_c, drop_c;

  assign trig_hit_c = commit_valid_i && (commit_pc_i == cfg_trig_pc_i);
  assign pop_c      = out_valid_o && out_ready_i;
  assign full_c     = (count_c == CNT_W'(DEPTH));

  assign entry_c = '{pc:      commit_pc_i,
                     instr:   commit_instr_i,
                     rd_we:   commit_rd_we_i,
                     rd_addr: commit_rd_addr_i,
                     rd_data: commit_rd_data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; dropping cfg_en_i returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = cfg_trig_en_i ? ARMED : CAPTURE;
        ARMED:   if (trig_hit_c) state_d = CAPTURE;
        CAPTURE: if (mode_q == STOP && commit_valid_i && !pop_c &&
                     count_c == CNT_W'(DEPTH - 1)) state_d = FROZEN;
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-state strobes; a commit in a cfg_en_i=0 cycle is ignored.
  always_comb begin
    clear_c  = 1'b0;
    push_c   = 1'b0;
    retire_c = 1'b0;
    drop_c   = 1'b0;
    case (state_q)
      IDLE:    clear_c = cfg_en_i;
      ARMED: begin
        push_c   = cfg_en_i && trig_hit_c;
        retire_c = cfg_en_i && commit_valid_i;
      end
      CAPTURE: begin
        push_c   = cfg_en_i && commit_valid_i;
        retire_c = cfg_en_i && commit_valid_i;
        drop_c   = push_c && full_c && !pop_c && (mode_q == OVERWRITE);
      end
      FROZEN: begin
        retire_c = cfg_en_i && commit_valid_i;
        drop_c   = cfg_en_i && commit_valid_i;
      end
      default: clear_c = 1'b0;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    retired_d = retired_q;
    dropped_d = dropped_q;
    if (clear_c) begin
      mode_d    = trace_mode_e'(cfg_mode_i);
      retired_d = '0;
      dropped_d = '0;
    end else begin
      if (retire_c) begin
        retired_d = retired_q + 64'd1;
      end
      if (drop_c && dropped_q != 32'hFFFF_FFFF) begin
        dropped_d = dropped_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= STOP;
      retired_q <= '0;
      dropped_q <= '0;
    end else begin
      mode_q    <= mode_d;
      retired_q <= retired_d;
      dropped_q <= dropped_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .ovw_i   (mode_q == OVERWRITE),
    .data_i  (entry_c),
    .head_o  (out_entry_o),
    .count_o (count_c)
  );

  assign out_valid_o = (count_c != '0);
  assign count_o     = count_c;
  assign retired_o   = retired_q;
  assign dropped_o   = dropped_q;
  assign state_o     = state_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retirement-trace capture block for the rv32 single-cycle core.
- Sits beside the core and takes one commit record per retired instruction: pc, instruction word and register writeback.
- Buffers records in a parametrised FIFO behind a trigger/arm state machine. A bench monitor or debug port drains the FIFO over a valid/ready handshake.
- Replaces ad-hoc per-update printing with counted, lossless or overwrite-mode capture.

Parameters:
- XLEN, riscv_pkg::XLEN (32), width of pc and rd data.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_en_i  in  1  capture enable.
- cfg_mode_i  in  1  0 = stop-on-full, 1 = overwrite-oldest. Sampled only on the IDLE->enable transition.
- cfg_trig_en_i  in  1  1 = wait for trigger pc, 0 = capture immediately.
- cfg_trig_pc_i  in  XLEN  trigger pc.
- commit_valid_i  in  1  one instruction retired this cycle.
- commit_pc_i  in  XLEN  retired pc.
- commit_instr_i  in  32  retired instruction word.
- commit_rd_we_i  in  1  register writeback valid.
- commit_rd_addr_i  in  5  destination register.
- commit_rd_data_i  in  XLEN  writeback data.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts head.
- out_entry_o  out  trace_entry_t  FIFO head record.
- count_o  out  CNT_W  occupancy.
- retired_o  out  64  commits seen while enabled.
- dropped_o  out  32  commits lost; saturating.
- state_o  out  2  current FSM state.

Behaviour:
- Reset state: state IDLE, pointers 0, count_o 0, out_valid_o 0, retired_o 0, dropped_o 0, latched mode 0. out_entry_o is don't-care while out_valid_o is 0.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.
- IDLE, cfg_en_i=1: clear FIFO, retired_o and dropped_o; latch cfg_mode_i. Next state is ARMED if cfg_trig_en_i, else CAPTURE.
- ARMED: on commit_valid_i with commit_pc_i == cfg_trig_pc_i, that commit is pushed as the first entry; next state CAPTURE.
- CAPTURE, stop mode: a push that makes count == DEPTH moves the FSM to FROZEN. Every later commit increments dropped_o.
- FROZEN: no pushes. Draining stays allowed. Leaves only when cfg_en_i = 0.
- Any state, cfg_en_i = 0: next state IDLE. FIFO contents are kept and remain drainable. A commit in that same cycle is ignored.
- Push: a commit_valid_i while in CAPTURE, or the trigger commit in ARMED. The entry is written at the clock edge; out_valid_o rises the cycle after the edge (latency 1).
- Pop: out_valid_o && out_ready_i. out_entry_o is the head, read combinationally from storage.
- count_o arithmetic: +1 on push only, -1 on pop only, unchanged on push+pop.
- Full, push with pop: legal in both modes. No drop.
- Full, push without pop, overwrite mode: the oldest entry is overwritten, the read pointer advances, count stays DEPTH, dropped_o += 1.
- Full, stop mode: covered by the CAPTURE->FROZEN rule. No overwrite ever occurs.
- Empty with push: no bypass. out_valid_o stays 0 in the push cycle.
- Pointers: log2(DEPTH) bits, natural wrap.
- retired_o: increments on every commit_valid_i while in ARMED, CAPTURE or FROZEN. Wraps at 2^64.
- dropped_o: saturates at 32'hFFFF_FFFF.
- Reset mid-operation: everything returns to reset values in one cycle, regardless of pending handshake.
- Trigger compare is full XLEN equality. Only the first match counts; later matches have no effect.

Decomposition:
- riscv_pkg gains:
  - trace_entry_t, packed: pc[XLEN], instr[32], rd_we, rd_addr[5], rd_data[XLEN].
  - trace_state_e {IDLE, ARMED, CAPTURE, FROZEN}.
  - trace_mode_e {STOP, OVERWRITE}.
- One sub-module, trace_fifo: storage, pointers, count and the overwrite-on-full option.
- The FSM and counters stay in commit_trace_buffer.

Test Plan:
- All tests use DEPTH=4.
- Immediate stop mode: enable with trig off, 6 commits pc 0x0..0x14 step 4, out_ready 0. Expect count 4, state FROZEN, dropped 2, retired 6. Drain yields pcs 0x0, 0x4, 0x8, 0xC.
- Overwrite mode: same stimulus with mode 1. Expect state CAPTURE, count 4, dropped 2. Drain yields 0x8, 0xC, 0x10, 0x14.
- Trigger: trig_pc 0x10, commits 0x0..0x1C. Expect ARMED until pc 0x10, first entry 0x10, 4 entries 0x10..0x1C, retired 8.
- Full with simultaneous push+pop, out_ready 1 while full, 10 commits. Expect count steady at 4, dropped 0, in-order output, no gaps.
- Latency: a single commit (pc 0x40, rd x5 = 0xDEAD) on a cycle with out_ready 1. Expect out_valid 0 that cycle, 1 the next, with the entry fields matching.
- Reset with count 3 and state FROZEN: rst_i high for 1 cycle. Expect all outputs at reset values next cycle; commits ignored until re-enabled.
